// File: rtl/bitonic_merge_scheduler.sv
// rtl/bitonic_merge_scheduler.sv - batch issue scheduler for one 2-to-1 bitonic merge-tree node
// Defining BMS_PERF_CNT_EN adds cycle/issue/credit-stall counters and a sticky credit-overflow flag.
module bitonic_merge_scheduler #(
  parameter int KEY_WIDTH   = 80,
  parameter int NET_LATENCY = 5,
  parameter int OUT_CREDITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_a_valid,
  input  logic                 i_a_last,
  input  logic [KEY_WIDTH-1:0] i_a_maxkey,
  output logic                 o_a_deq,
  input  logic                 i_b_valid,
  input  logic                 i_b_last,
  input  logic [KEY_WIDTH-1:0] i_b_maxkey,
  output logic                 o_b_deq,
  input  logic                 i_out_deq,
  output logic                 o_issue,
  output logic                 o_sel,
  output logic                 o_flush,
  output logic                 o_out_valid,
  output logic                 o_done,
  output logic                 o_busy
`ifdef BMS_PERF_CNT_EN
  ,
  output logic [31:0]          o_cyc_cnt,
  output logic [31:0]          o_iss_cnt,
  output logic [31:0]          o_crd_stall_cnt,
  output logic                 o_crd_err
`endif
);

  localparam int CW = $clog2(OUT_CREDITS + 1);
  localparam int GW = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
  localparam logic [CW-1:0] CRD_MAX = CW'(OUT_CREDITS);

  typedef enum logic [2:0] {
    S_IDLE, S_MERGE, S_DRAIN_A, S_DRAIN_B, S_FLUSH, S_WAIT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          credits;
  logic [GW-1:0]          gap;
  logic [NET_LATENCY-1:0] vld_sr;
  logic [NET_LATENCY-1:0] flush_sr;
  logic                   a_done;
  logic                   b_done;
  logic                   sel;
  logic                   src_ok;
  logic                   issue;
  logic                   in_flush;
  logic                   a_done_nx;
  logic                   b_done_nx;

  // The batch with the smaller max key goes first; a tie favours A.
  always_comb begin
    sel    = 1'b0;
    src_ok = 1'b0;
    case (state)
      S_MERGE: begin
        sel    = (i_b_maxkey < i_a_maxkey);
        src_ok = i_a_valid & i_b_valid;
      end
      S_DRAIN_A: src_ok = i_a_valid;
      S_DRAIN_B: begin
        sel    = 1'b1;
        src_ok = i_b_valid;
      end
      S_FLUSH: src_ok = 1'b1;
      default: ;
    endcase
  end

  assign in_flush    = (state == S_FLUSH);
  assign issue       = src_ok & (gap == '0) & (credits != '0);
  assign o_issue     = issue;
  assign o_sel       = issue & sel & ~in_flush;
  assign o_flush     = issue & in_flush;
  assign o_a_deq     = issue & ~in_flush & ~sel;
  assign o_b_deq     = issue & ~in_flush & sel;
  assign a_done_nx   = a_done | (o_a_deq & i_a_last);
  assign b_done_nx   = b_done | (o_b_deq & i_b_last);
  assign o_out_valid = vld_sr[NET_LATENCY-1];
  assign o_done      = (state == S_WAIT) & flush_sr[NET_LATENCY-1];
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      credits  <= CRD_MAX;
      gap      <= '0;
      vld_sr   <= '0;
      flush_sr <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
    end else begin
      vld_sr   <= (vld_sr << 1) | NET_LATENCY'(issue);
      flush_sr <= (flush_sr << 1) | NET_LATENCY'(o_flush);

      if (issue)
        gap <= GW'(NET_LATENCY - 1);
      else if (gap != '0)
        gap <= gap - GW'(1);

      // A return at full credits is dropped so the count never exceeds the FIFO depth.
      if (issue && !i_out_deq)
        credits <= credits - CW'(1);
      else if (!issue && i_out_deq && credits != CRD_MAX)
        credits <= credits + CW'(1);

      a_done <= a_done_nx;
      b_done <= b_done_nx;

      case (state)
        S_IDLE: if (i_start) begin
          state  <= S_MERGE;
          a_done <= 1'b0;
          b_done <= 1'b0;
        end
        S_MERGE: if (a_done_nx | b_done_nx)
          state <= b_done_nx ? S_DRAIN_A : S_DRAIN_B;
        S_DRAIN_A, S_DRAIN_B: if (a_done_nx & b_done_nx)
          state <= S_FLUSH;
        S_FLUSH: if (issue)
          state <= S_WAIT;
        S_WAIT: if (flush_sr[NET_LATENCY-1])
          state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BMS_PERF_CNT_EN
  logic deq_full;
  assign deq_full = i_out_deq & ~issue & (credits == CRD_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cyc_cnt       <= '0;
      o_iss_cnt       <= '0;
      o_crd_stall_cnt <= '0;
      o_crd_err       <= 1'b0;
    end else begin
      if (deq_full)
        o_crd_err <= 1'b1;
      if (state == S_IDLE && i_start) begin
        o_cyc_cnt       <= '0;
        o_iss_cnt       <= '0;
        o_crd_stall_cnt <= '0;
      end else begin
        if (state != S_IDLE)
          o_cyc_cnt <= o_cyc_cnt + 32'd1;
        if (issue)
          o_iss_cnt <= o_iss_cnt + 32'd1;
        if (src_ok && gap == '0 && credits == '0 && o_crd_stall_cnt != '1)
          o_crd_stall_cnt <= o_crd_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bitonic_merge_scheduler.sv
// tb/tb_bitonic_merge_scheduler.sv - randomized bench for bitonic_merge_scheduler
// A queue-based stream/credit model is compared against the DUT every cycle.
module tb_bitonic_merge_scheduler;
  localparam int KW = 80;
  localparam int L  = 5;
  localparam int OC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, start = 1'b0, out_deq = 1'b0;
  logic          a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [KW-1:0] a_maxkey = '0, b_maxkey = '0;
  logic          a_deq, b_deq, issue, sel, flush, out_valid, done, busy;

  always #5 clk = ~clk;

  bitonic_merge_scheduler #(.KEY_WIDTH(KW), .NET_LATENCY(L), .OUT_CREDITS(OC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_a_valid(a_valid), .i_a_last(a_last), .i_a_maxkey(a_maxkey), .o_a_deq(a_deq),
    .i_b_valid(b_valid), .i_b_last(b_last), .i_b_maxkey(b_maxkey), .o_b_deq(b_deq),
    .i_out_deq(out_deq), .o_issue(issue), .o_sel(sel), .o_flush(flush),
    .o_out_valid(out_valid), .o_done(done), .o_busy(busy)
  );

  typedef enum int {M_IDLE, M_MERGE, M_DRAIN_A, M_DRAIN_B, M_FLUSH, M_WAIT} phase_t;

  phase_t        ph = M_IDLE;
  int            credits = OC, next_ok = 0, flush_cyc = 0;
  bit            issued_at[int];
  logic [KW-1:0] qa[$], qb[$];
  bit            gate_a = 1'b1, gate_b = 1'b1, rnd_gate = 1'b0, chk_en = 1'b0;
  int            cyc = 0, n_chk = 0, n_fail = 0;
  int            iss_cyc[$], iss_kind[$];
  int            done_cyc = -1, ov_cnt = 0, done_cnt = 0;
  int            exp_basic[5]  = '{0, 1, 0, 1, 2};
  int            exp_tie[3]    = '{0, 1, 2};
  int            exp_uneven[5] = '{0, 1, 1, 1, 2};
  int            exp_gap[7]    = '{0, 1, 0, 1, 0, 1, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs follow from stream heads, the credit count and the time of the last issue.
  task automatic model_cycle();
    bit src, e_sel, e_issue, e_flush, e_a, e_b, e_ov, e_done, a_lst, b_lst;
    src   = 1'b0;
    e_sel = 1'b0;
    a_lst = (qa.size() == 1);
    b_lst = (qb.size() == 1);
    case (ph)
      M_MERGE: begin
        src = a_valid && b_valid;
        if (src) e_sel = (qb[0] < qa[0]);
      end
      M_DRAIN_A: src = a_valid;
      M_DRAIN_B: begin src = b_valid; e_sel = 1'b1; end
      M_FLUSH:   src = 1'b1;
      default:   src = 1'b0;
    endcase
    e_issue = src && (cyc >= next_ok) && (credits > 0);
    e_flush = e_issue && (ph == M_FLUSH);
    e_a     = e_issue && !e_flush && !e_sel;
    e_b     = e_issue && !e_flush && e_sel;
    e_ov    = issued_at.exists(cyc - L);
    e_done  = (ph == M_WAIT) && (cyc == flush_cyc + L);
    if (chk_en) begin
      chk("issue", issue, e_issue);
      chk("flush", flush, e_flush);
      chk("a_deq", a_deq, e_a);
      chk("b_deq", b_deq, e_b);
      chk("out_valid", out_valid, e_ov);
      chk("done", done, e_done);
      chk("busy", busy, ph != M_IDLE);
      if (e_a || e_b) chk("sel", sel, e_sel);
    end
    if (!rst_n) begin
      ph      = M_IDLE;
      credits = OC;
      next_ok = 0;
      issued_at.delete();
      return;
    end
    credits = credits - int'(e_issue) + int'(out_deq);
    if (credits > OC) credits = OC;
    if (e_issue) begin
      next_ok = cyc + L;
      issued_at[cyc] = 1'b1;
    end
    if (e_a) void'(qa.pop_front());
    if (e_b) void'(qb.pop_front());
    case (ph)
      M_IDLE:    if (start) ph = M_MERGE;
      M_MERGE:   if (e_a && a_lst) ph = M_DRAIN_B; else if (e_b && b_lst) ph = M_DRAIN_A;
      M_DRAIN_A: if (e_a && a_lst) ph = M_FLUSH;
      M_DRAIN_B: if (e_b && b_lst) ph = M_FLUSH;
      M_FLUSH:   if (e_issue) begin ph = M_WAIT; flush_cyc = cyc; end
      M_WAIT:    if (e_done) ph = M_IDLE;
      default:   ;
    endcase
  endtask

  task automatic step(input bit st, input bit rs, input bit od);
    @(posedge clk);
    #1;
    cyc++;
    rst_n   = !rs;
    start   = st;
    out_deq = od;
    if (rnd_gate) begin
      gate_a = ($urandom_range(0, 99) < 80);
      gate_b = ($urandom_range(0, 99) < 80);
    end
    a_valid  = gate_a && (qa.size() != 0);
    a_last   = (qa.size() == 1);
    a_maxkey = (qa.size() != 0) ? qa[0] : '0;
    b_valid  = gate_b && (qb.size() != 0);
    b_last   = (qb.size() == 1);
    b_maxkey = (qb.size() != 0) ? qb[0] : '0;
    #1;
    if (issue === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_kind.push_back(flush ? 2 : (sel ? 1 : 0));
    end
    if (out_valid === 1'b1) ov_cnt++;
    if (done === 1'b1) begin done_cyc = cyc; done_cnt++; end
    model_cycle();
  endtask

  task automatic run_idle(input int budget, input int deq_pct);
    int i;
    i = 0;
    while (ph != M_IDLE && i < budget) begin
      step(1'b0, 1'b0, $urandom_range(0, 99) < deq_pct);
      i++;
    end
    chk("merge_completes", ph == M_IDLE, 1);
  endtask

  task automatic clear_obs();
    iss_cyc.delete();
    iss_kind.delete();
    done_cyc = -1;
    ov_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic refill();
    for (int i = 0; i < OC + 2; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [KW-1:0] rkey();
    if ($urandom_range(0, 1) == 1) return KW'($urandom_range(0, 7));
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, dq, n;
    step(1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_issue", issue, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);

    // Basic merge: A = 10,30 / B = 20,40.
    clear_obs();
    qa = '{80'd10, 80'd30};
    qb = '{80'd20, 80'd40};
    step(1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
    run_idle(200, 0);
    chk("basic_n_issue", iss_cyc.size(), 5);
    if (iss_cyc.size() == 5) begin
      chk("basic_first_issue", iss_cyc[0] - start_cyc, 1);
      for (int i = 0; i < 5; i++) begin
        chk("basic_spacing", iss_cyc[i] - iss_cyc[0], 5 * i);
        chk("basic_kind", iss_kind[i], exp_basic[i]);
      end
      chk("basic_done_time", done_cyc - iss_cyc[0], 25);
    end
    chk("basic_out_valid_cnt", ov_cnt, 5);
    chk("basic_done_cnt", done_cnt, 1);

    // Tie on equal max keys selects A.
    refill();
    clear_obs();
    qa = '{80'd7};
    qb = '{80'd7};
    step(1'b1, 1'b0, 1'b0);
    run_idle(200, 0);
    chk("tie_n_issue", iss_cyc.size(), 3);
    if (iss_cyc.size() == 3)
      for (int i = 0; i < 3; i++) chk("tie_kind", iss_kind[i], exp_tie[i]);

    // Backpressure: credits run out, a single return releases one issue.
    refill();
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      qa.push_back(KW'(2 * i + 1));
      qb.push_back(KW'(2 * i + 2));
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b0, 1'b0);
    chk("bp_issue_cnt", iss_cyc.size(), OC);
    step(1'b0, 1'b0, 1'b1);
    dq = cyc;
    repeat (10) step(1'b0, 1'b0, 1'b0);
    chk("bp_one_more", iss_cyc.size(), OC + 1);
    if (iss_cyc.size() == OC + 1) chk("bp_issue_after_deq", iss_cyc[OC] - dq, 1);
    run_idle(600, 100);

    // Uneven streams: A has one batch, B drains alone.
    refill();
    clear_obs();
    qa = '{80'd1};
    qb = '{80'd5, 80'd6, 80'd7};
    step(1'b1, 1'b0, 1'b0);
    run_idle(200, 0);
    chk("uneven_n_issue", iss_cyc.size(), 5);
    if (iss_cyc.size() == 5)
      for (int i = 0; i < 5; i++) chk("uneven_kind", iss_kind[i], exp_uneven[i]);
    chk("uneven_done_cnt", done_cnt, 1);

    // Source gap: B invalid for 12 cycles mid-merge.
    refill();
    clear_obs();
    qa = '{80'd1, 80'd3, 80'd5};
    qb = '{80'd2, 80'd4, 80'd6};
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_first_issue", iss_cyc.size(), 1);
    gate_b = 1'b0;
    n = iss_cyc.size();
    repeat (12) step(1'b0, 1'b0, 1'b0);
    chk("gap_no_issue", iss_cyc.size(), n);
    gate_b = 1'b1;
    run_idle(300, 0);
    chk("gap_n_issue", iss_cyc.size(), 7);
    if (iss_cyc.size() == 7)
      for (int i = 0; i < 7; i++) chk("gap_kind", iss_kind[i], exp_gap[i]);

    // Reset after the second issue abandons the merge.
    refill();
    clear_obs();
    qa = '{80'd1, 80'd3, 80'd5};
    qb = '{80'd2, 80'd4, 80'd6};
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50 && iss_cyc.size() < 2; i++) step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_reach2", iss_cyc.size(), 2);
    step(1'b0, 1'b1, 1'b0);
    qa.delete();
    qb.delete();
    ov_cnt   = 0;
    done_cnt = 0;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_issue", issue, 0);
    chk("rst_mid_deq", {a_deq, b_deq}, 0);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_ov_quiet", ov_cnt, 0);
    chk("rst_mid_no_done", done_cnt, 0);
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      qa.push_back(KW'(2 * i + 1));
      qb.push_back(KW'(2 * i + 2));
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_credits_full", iss_cyc.size(), OC);
    run_idle(600, 100);

    // Randomized merges with random valid gaps and credit returns.
    rnd_gate = 1'b1;
    for (int m = 0; m < 25; m++) begin
      int na, nb;
      na = $urandom_range(1, 4);
      nb = $urandom_range(1, 4);
      for (int i = 0; i < na; i++) qa.push_back(rkey());
      for (int i = 0; i < nb; i++) qb.push_back(rkey());
      repeat ($urandom_range(0, 4)) step(1'b0, 1'b0, $urandom_range(0, 1) == 1);
      step(1'b1, 1'b0, 1'b0);
      run_idle(1500, 40);
    end
    rnd_gate = 1'b0;
    gate_a   = 1'b1;
    gate_b   = 1'b1;
    repeat (8) step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
